forward_hazard_unit: RTL and testbench

//  Producer side of the ALU operand-mux select interface. Tracks dest regs of the EX (DEC_ALU),
//  MEM (ALU_MEM) and WB (MEM_WB) stages and drives registered select1/select2 so they are valid
//  in the same cycle the consumer instruction is in EX. Detects load-use hazards and stalls IF/DEC.

---
 rtl/forward_hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select generator and load-use hazard detector for the ALU input muxes.
// Selects are registered so they line up with the consumer instruction while it sits in EX.
`ifndef ALU_MUX_SELECT_DEFINES
`define ALU_MUX_SELECT_DEFINES
`define ALUMuxSelectBus        [1:0]
`define ALUMuxDataFromReg      2'd0
`define ALUMuxDataFromALU_MEM  2'd1
`define ALUMuxDataFromMEM_WB   2'd2
`endif

module forward_hazard_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_is_load,
    input  logic                    flush,
    input  logic                    freeze,
    output logic `ALUMuxSelectBus   select1,
    output logic `ALUMuxSelectBus   select2,
    output logic                    stall
);

    localparam int CNT_W = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_USE_STALL - 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;

    logic                    ex_valid;
    logic                    ex_reg_write;
    logic                    ex_is_load;
    logic [REG_ADDR_W-1:0]   ex_rd;

    // The WB stage is never read: next cycle's WB is this cycle's MEM, so MEM is all we keep.
    logic                    mem_valid;
    logic                    mem_reg_write;
    logic [REG_ADDR_W-1:0]   mem_rd;

    logic                    hz;
    logic                    issue;
    logic `ALUMuxSelectBus   sel1_next;
    logic `ALUMuxSelectBus   sel2_next;

    // Newest producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic `ALUMuxSelectBus fwd_select(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  nmem_valid,
        input logic                  nmem_reg_write,
        input logic [REG_ADDR_W-1:0] nmem_rd,
        input logic                  nwb_valid,
        input logic                  nwb_reg_write,
        input logic [REG_ADDR_W-1:0] nwb_rd
    );
        logic `ALUMuxSelectBus sel;
        sel = `ALUMuxDataFromReg;
        if (used && (rs != '0)) begin
            if (nmem_valid && nmem_reg_write && (nmem_rd == rs))
                sel = `ALUMuxDataFromALU_MEM;
            else if (nwb_valid && nwb_reg_write && (nwb_rd == rs))
                sel = `ALUMuxDataFromMEM_WB;
        end
        return sel;
    endfunction

    assign hz = id_valid & ex_valid & ex_is_load & ex_reg_write & (ex_rd != '0) &
                ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

    assign stall = (state == STALL) | hz;
    assign issue = id_valid & ~stall;

    always_comb begin
        sel1_next = fwd_select(id_rs1_used, id_rs1, ex_valid, ex_reg_write, ex_rd,
                               mem_valid, mem_reg_write, mem_rd);
        sel2_next = fwd_select(id_rs2_used, id_rs2, ex_valid, ex_reg_write, ex_rd,
                               mem_valid, mem_reg_write, mem_rd);
    end

    // Flush kills the DEC instruction but still lets older instructions drain; freeze holds everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_rd         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            select1       <= `ALUMuxDataFromReg;
            select2       <= `ALUMuxDataFromReg;
            state         <= RUN;
            cnt           <= '0;
        end else if (flush) begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_rd         <= '0;
            select1       <= `ALUMuxDataFromReg;
            select2       <= `ALUMuxDataFromReg;
            state         <= RUN;
            cnt           <= '0;
        end else if (!freeze) begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            if (issue) begin
                ex_valid     <= 1'b1;
                ex_reg_write <= id_reg_write;
                ex_is_load   <= id_is_load;
                ex_rd        <= id_rd;
                select1      <= sel1_next;
                select2      <= sel2_next;
            end else begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_is_load   <= 1'b0;
                ex_rd        <= '0;
                select1      <= `ALUMuxDataFromReg;
                select2      <= `ALUMuxDataFromReg;
            end
            case (state)
                RUN: begin
                    if (hz && (LOAD_USE_STALL > 1)) begin
                        state <= STALL;
                        cnt   <= CNT_W'(1);
                    end
                end
                STALL: begin
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: one instance with a 1-cycle load-use stall, one with 3.
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
`ifndef ALU_MUX_SELECT_DEFINES
`define ALU_MUX_SELECT_DEFINES
`define ALUMuxSelectBus        [1:0]
`define ALUMuxDataFromReg      2'd0
`define ALUMuxDataFromALU_MEM  2'd1
`define ALUMuxDataFromMEM_WB   2'd2
`endif

module tb_forward_hazard_unit;

    localparam int W = 5;
    localparam logic [1:0] R = `ALUMuxDataFromReg;
    localparam logic [1:0] A = `ALUMuxDataFromALU_MEM;
    localparam logic [1:0] M = `ALUMuxDataFromMEM_WB;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid;
    logic [W-1:0] id_rs1;
    logic [W-1:0] id_rs2;
    logic         id_rs1_used;
    logic         id_rs2_used;
    logic [W-1:0] id_rd;
    logic         id_reg_write;
    logic         id_is_load;
    logic         flush;
    logic         freeze;

    logic [1:0]   sel1_a, sel2_a, sel1_b, sel2_b;
    logic         stall_a, stall_b;

    typedef struct packed {
        logic       chk_a;
        logic [1:0] s1_a;
        logic [1:0] s2_a;
        logic       st_a;
        logic       chk_b;
        logic [1:0] s1_b;
        logic [1:0] s2_b;
        logic       st_b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.REG_ADDR_W(W), .LOAD_USE_STALL(1)) u_stall1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .freeze(freeze),
        .select1(sel1_a), .select2(sel2_a), .stall(stall_a)
    );

    forward_hazard_unit #(.REG_ADDR_W(W), .LOAD_USE_STALL(3)) u_stall3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .freeze(freeze),
        .select1(sel1_b), .select2(sel2_b), .stall(stall_b)
    );

    task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One instruction slot in DEC for the coming cycle, driven just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                                 input logic u1, input logic u2, input logic [W-1:0] rd,
                                 input logic rw, input logic ld, input logic fl, input logic fz);
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        flush        = fl;
        freeze       = fz;
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pushExpect(input string name,
                              input logic ca, input logic [1:0] a1, input logic [1:0] a2, input logic sa,
                              input logic cb, input logic [1:0] b1, input logic [1:0] b2, input logic sb);
        exp_t e;
        e.chk_a = ca; e.s1_a = a1; e.s2_a = a2; e.st_a = sa;
        e.chk_b = cb; e.s1_b = b1; e.s2_b = b2; e.st_b = sb;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (e.chk_a) begin
                    checkOutput({n, " s1.select1"}, sel1_a, e.s1_a);
                    checkOutput({n, " s1.select2"}, sel2_a, e.s2_a);
                    checkOutput({n, " s1.stall"}, {1'b0, stall_a}, {1'b0, e.st_a});
                end
                if (e.chk_b) begin
                    checkOutput({n, " s3.select1"}, sel1_b, e.s1_b);
                    checkOutput({n, " s3.select2"}, sel2_b, e.s2_b);
                    checkOutput({n, " s3.stall"}, {1'b0, stall_b}, {1'b0, e.st_b});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        // Reset with busy-looking inputs on the DEC side.
        rst = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        id_rd = 5'd5; id_reg_write = 1'b1; id_is_load = 1'b1; flush = 1'b0; freeze = 1'b0;
        @(posedge clk);
        #1;
        pushExpect("reset.c1", 1, R, R, 0, 1, R, R, 0);
        @(posedge clk);
        #1;
        pushExpect("reset.c2", 1, R, R, 0, 1, R, R, 0);
        rst = 1'b1;
        id_valid = 1'b0;
        id_is_load = 1'b0;

        // add x5 ; add x6,x5,x7
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0);
        applyStimulus(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0);
        pushExpect("alu.producer", 1, R, R, 0, 1, R, R, 0);
        nop();
        pushExpect("alu.fwd_exmem", 1, A, R, 0, 1, A, R, 0);

        // addi x3 ; nop ; sub x4,x1,x3
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
        nop();
        pushExpect("addi.regs", 1, R, R, 0, 1, R, R, 0);
        applyStimulus(1, 5'd1, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0);
        nop();
        pushExpect("fwd.memwb", 1, R, M, 0, 1, R, M, 0);

        // addi x3 ; addi x3 ; sub x4,x1,x3 : newest producer wins
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0);
        applyStimulus(1, 5'd1, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0);
        nop();
        pushExpect("fwd.newest", 1, R, A, 0, 1, R, A, 0);

        // Unused rs1 field matches but must not forward
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0);
        applyStimulus(1, 5'd9, 5'd9, 0, 1, 5'd10, 1, 0, 0, 0);
        nop();
        pushExpect("fwd.unused_rs", 1, R, A, 0, 1, R, A, 0);

        // Producer without reg_write must not forward
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd11, 0, 0, 0, 0);
        applyStimulus(1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 0, 0);
        nop();
        pushExpect("fwd.no_write", 1, R, R, 0, 1, R, R, 0);

        // lw x8 ; add x9,x8,x8 held in DEC while stalled
        doReset();
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("lu.d1", 1, R, R, 1, 1, R, R, 1);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("lu.d2", 1, R, R, 0, 1, R, R, 1);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("lu.d3", 1, M, M, 0, 1, R, R, 1);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("lu.d4", 1, R, R, 0, 1, R, R, 0);
        nop();
        pushExpect("lu.d5", 1, R, R, 0, 1, R, R, 0);

        // x0 is never forwarded and a load to x0 never stalls
        doReset();
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0, 0, 0);
        nop();
        pushExpect("x0.alu", 1, R, R, 0, 1, R, R, 0);
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0);
        pushExpect("x0.load_nostall", 1, R, R, 0, 1, R, R, 0);
        nop();
        pushExpect("x0.load_sel", 1, R, R, 0, 1, R, R, 0);

        // freeze during the 3-cycle stall, then flush while still stalled
        doReset();
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("fz.f1", 1, R, R, 1, 1, R, R, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 1);
            pushExpect($sformatf("fz.hold%0d", i), 1, R, R, 0, 1, R, R, 1);
        end
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 1, 0);
        pushExpect("fz.flush_cycle", 1, R, R, 0, 1, R, R, 1);
        applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        pushExpect("fz.after_flush", 1, R, R, 0, 1, R, R, 0);
        nop();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
